// File: rtl/readout_rx_bin_count_trial_ctrl_if.sv
// Handshake/bus bundle between the readout sample feeder, the bin-count/trial
// controller and the downstream state-decision stage.
interface readout_rx_bin_count_trial_ctrl_if #(
    parameter int BIN_COUNTER_WIDTH           = 16,
    parameter int THRESHOLD_MEMORY_ADDR_WIDTH = 4,
    parameter int TRIAL_IDX_WIDTH             = 4
);
    // Measurement control from the sequencer
    logic                                   start_in;
    logic [THRESHOLD_MEMORY_ADDR_WIDTH-1:0] threshold_addr_in;
    // Classified sample stream
    logic                                   sample_valid_in;
    logic                                   sample_state_in;
    logic                                   sample_ready_out;
    // Decision stage feedback
    logic                                   decision_fin_in;
    // Results towards the decision stage
    logic [BIN_COUNTER_WIDTH-1:0]           bin_count_out;
    logic                                   finish_trial_out;
    logic                                   last_trial_out;
    logic [THRESHOLD_MEMORY_ADDR_WIDTH-1:0] threshold_addr_out;
    logic [TRIAL_IDX_WIDTH-1:0]             trial_idx_out;
    logic                                   busy_out;

    // Side that drives start/samples/decision and consumes results
    modport master (
        output start_in, threshold_addr_in, sample_valid_in, sample_state_in, decision_fin_in,
        input  sample_ready_out, bin_count_out, finish_trial_out, last_trial_out,
               threshold_addr_out, trial_idx_out, busy_out
    );

    // The controller itself
    modport slave (
        input  start_in, threshold_addr_in, sample_valid_in, sample_state_in, decision_fin_in,
        output sample_ready_out, bin_count_out, finish_trial_out, last_trial_out,
               threshold_addr_out, trial_idx_out, busy_out
    );
endinterface

// File: rtl/readout_rx_bin_count_trial_ctrl.sv
// Readout RX bin-count / trial controller.
// Accumulates classified samples into an offset-binary count (#|1> - #|0> + MID),
// cuts the measurement into fixed-length trials and strobes the decision stage at
// the end of each trial. The count is cumulative across trials of one measurement.
module readout_rx_bin_count_trial_ctrl #(
    parameter int BIN_COUNTER_WIDTH           = 16,
    parameter int SAMPLES_PER_TRIAL           = 16,
    parameter int SAMPLE_COUNT_WIDTH          = 8,
    parameter int MAX_TRIALS                  = 8,
    parameter int TRIAL_IDX_WIDTH             = 4,
    parameter int THRESHOLD_MEMORY_ADDR_WIDTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    readout_rx_bin_count_trial_ctrl_if.slave     bus
);

    localparam logic [BIN_COUNTER_WIDTH-1:0] BIN_MID =
        {1'b1, {(BIN_COUNTER_WIDTH-1){1'b0}}};
    localparam logic [BIN_COUNTER_WIDTH-1:0] BIN_MAX = {BIN_COUNTER_WIDTH{1'b1}};
    localparam logic [BIN_COUNTER_WIDTH-1:0] BIN_MIN = {BIN_COUNTER_WIDTH{1'b0}};
    localparam logic [SAMPLE_COUNT_WIDTH-1:0] CNT_LAST =
        SAMPLE_COUNT_WIDTH'(SAMPLES_PER_TRIAL - 1);
    localparam logic [TRIAL_IDX_WIDTH-1:0] TRIAL_LAST =
        TRIAL_IDX_WIDTH'(MAX_TRIALS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t                                 r_state;
    state_t                                 w_state_nxt;
    logic [BIN_COUNTER_WIDTH-1:0]           r_bin;
    logic [SAMPLE_COUNT_WIDTH-1:0]          r_cnt;
    logic [TRIAL_IDX_WIDTH-1:0]             r_trial;
    logic [THRESHOLD_MEMORY_ADDR_WIDTH-1:0] r_addr;

    logic w_accept;
    logic w_trial_done;
    logic w_is_last;
    logic w_ready;
    logic w_finish;
    logic w_last;
    logic w_busy;

    // Saturating +/-1 step of the bin count; never wraps at either end.
    function automatic logic [BIN_COUNTER_WIDTH-1:0] sat_step(
        input logic [BIN_COUNTER_WIDTH-1:0] bin,
        input logic                         up
    );
        logic [BIN_COUNTER_WIDTH-1:0] res;
        if (up) begin
            res = (bin == BIN_MAX) ? bin : bin + BIN_COUNTER_WIDTH'(1);
        end else begin
            res = (bin == BIN_MIN) ? bin : bin - BIN_COUNTER_WIDTH'(1);
        end
        return res;
    endfunction

    assign w_accept     = (r_state == ST_ACCUM) && bus.sample_valid_in;
    assign w_trial_done = w_accept && (r_cnt == CNT_LAST);
    assign w_is_last    = (r_trial == TRIAL_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and Moore strobe decode; decision_fin_in only steers the transition.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_finish    = 1'b0;
        w_last      = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start_in) begin
                    w_state_nxt = ST_ACCUM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (w_trial_done) begin
                    w_state_nxt = ST_FINISH;
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_FINISH: begin
                w_finish = 1'b1;
                w_busy   = 1'b1;
                w_last   = w_is_last;
                if (bus.decision_fin_in || w_is_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: address latch, cumulative bin count, sample counter, trial index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin   <= BIN_MID;
            r_cnt   <= {SAMPLE_COUNT_WIDTH{1'b0}};
            r_trial <= {TRIAL_IDX_WIDTH{1'b0}};
            r_addr  <= {THRESHOLD_MEMORY_ADDR_WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_in) begin
                        r_addr  <= bus.threshold_addr_in;
                        r_bin   <= BIN_MID;
                        r_cnt   <= {SAMPLE_COUNT_WIDTH{1'b0}};
                        r_trial <= {TRIAL_IDX_WIDTH{1'b0}};
                    end
                end
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_bin <= sat_step(r_bin, bus.sample_state_in);
                        if (w_trial_done) begin
                            r_cnt <= {SAMPLE_COUNT_WIDTH{1'b0}};
                        end else begin
                            r_cnt <= r_cnt + SAMPLE_COUNT_WIDTH'(1);
                        end
                    end
                end
                ST_FINISH: begin
                    // Trial index only advances when another trial follows.
                    if (!bus.decision_fin_in && !w_is_last) begin
                        r_trial <= r_trial + TRIAL_IDX_WIDTH'(1);
                    end
                end
                default: begin
                    r_cnt <= {SAMPLE_COUNT_WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign bus.sample_ready_out   = w_ready;
    assign bus.finish_trial_out   = w_finish;
    assign bus.last_trial_out     = w_last;
    assign bus.busy_out           = w_busy;
    assign bus.bin_count_out      = r_bin;
    assign bus.trial_idx_out      = r_trial;
    assign bus.threshold_addr_out = r_addr;

endmodule

// File: tb/tb_readout_rx_bin_count_trial_ctrl.sv
// Self-checking bench: a W=16 and a W=4 instance share one stimulus stream and
// are compared every cycle against a measurement-level model, with literal
// expectations at the key points of the directed scenarios.
module tb_readout_rx_bin_count_trial_ctrl;

    localparam int SPT  = 4;
    localparam int MAXT = 3;
    localparam int AW   = 4;
    localparam int TW   = 4;

    logic clk = 1'b0;
    logic rst;
    logic t_start;
    logic [AW-1:0] t_addr;
    logic t_valid;
    logic t_state;
    logic t_dec;

    always #5 clk = ~clk;

    readout_rx_bin_count_trial_ctrl_if #(.BIN_COUNTER_WIDTH(16), .THRESHOLD_MEMORY_ADDR_WIDTH(AW),
                                         .TRIAL_IDX_WIDTH(TW)) if_a ();
    readout_rx_bin_count_trial_ctrl_if #(.BIN_COUNTER_WIDTH(4), .THRESHOLD_MEMORY_ADDR_WIDTH(AW),
                                         .TRIAL_IDX_WIDTH(TW)) if_b ();

    assign if_a.start_in          = t_start;
    assign if_a.threshold_addr_in = t_addr;
    assign if_a.sample_valid_in   = t_valid;
    assign if_a.sample_state_in   = t_state;
    assign if_a.decision_fin_in   = t_dec;
    assign if_b.start_in          = t_start;
    assign if_b.threshold_addr_in = t_addr;
    assign if_b.sample_valid_in   = t_valid;
    assign if_b.sample_state_in   = t_state;
    assign if_b.decision_fin_in   = t_dec;

    readout_rx_bin_count_trial_ctrl #(
        .BIN_COUNTER_WIDTH(16), .SAMPLES_PER_TRIAL(SPT), .SAMPLE_COUNT_WIDTH(8),
        .MAX_TRIALS(MAXT), .TRIAL_IDX_WIDTH(TW), .THRESHOLD_MEMORY_ADDR_WIDTH(AW)
    ) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));

    readout_rx_bin_count_trial_ctrl #(
        .BIN_COUNTER_WIDTH(4), .SAMPLES_PER_TRIAL(SPT), .SAMPLE_COUNT_WIDTH(8),
        .MAX_TRIALS(MAXT), .TRIAL_IDX_WIDTH(TW), .THRESHOLD_MEMORY_ADDR_WIDTH(AW)
    ) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- measurement-level model (index 0: W=16, 1: W=4) -------------
    int m_max[2] = '{65535, 15};
    int m_mid[2] = '{32768, 8};
    bit m_known = 1'b0;
    bit m_busy[2];
    bit m_fin[2];
    int m_taken[2];
    int m_trial[2];
    int m_bin[2];
    int m_addr[2];

    // Compare on the falling edge, then advance the model with the inputs that the
    // next rising edge will sample.
    initial begin
        int act[2][7];
        int exp[2][7];
        string nm[7];
        nm = '{"ready", "finish", "last", "busy", "bin", "trial", "addr"};
        forever begin
            @(negedge clk);
            if (m_known) begin
                act[0] = '{int'(if_a.sample_ready_out), int'(if_a.finish_trial_out),
                           int'(if_a.last_trial_out), int'(if_a.busy_out),
                           int'(if_a.bin_count_out), int'(if_a.trial_idx_out),
                           int'(if_a.threshold_addr_out)};
                act[1] = '{int'(if_b.sample_ready_out), int'(if_b.finish_trial_out),
                           int'(if_b.last_trial_out), int'(if_b.busy_out),
                           int'(if_b.bin_count_out), int'(if_b.trial_idx_out),
                           int'(if_b.threshold_addr_out)};
                for (int k = 0; k < 2; k++) begin
                    exp[k] = '{int'(m_busy[k] && !m_fin[k]), int'(m_fin[k]),
                               int'(m_fin[k] && (m_trial[k] == MAXT - 1)), int'(m_busy[k]),
                               m_bin[k], m_trial[k], m_addr[k]};
                    for (int j = 0; j < 7; j++) begin
                        check($sformatf("model_%s_w%0d", nm[j], (k == 0) ? 16 : 4),
                              act[k][j], exp[k][j]);
                    end
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    m_busy[k] = 1'b0; m_fin[k] = 1'b0; m_taken[k] = 0;
                    m_trial[k] = 0; m_addr[k] = 0; m_bin[k] = m_mid[k];
                end else if (!m_busy[k]) begin
                    if (t_start) begin
                        m_busy[k] = 1'b1; m_addr[k] = int'(t_addr); m_bin[k] = m_mid[k];
                        m_taken[k] = 0; m_trial[k] = 0;
                    end
                end else if (m_fin[k]) begin
                    m_fin[k] = 1'b0;
                    if (t_dec || (m_trial[k] == MAXT - 1)) m_busy[k] = 1'b0;
                    else m_trial[k]++;
                end else if (t_valid) begin
                    if (t_state) m_bin[k] = (m_bin[k] < m_max[k]) ? m_bin[k] + 1 : m_bin[k];
                    else         m_bin[k] = (m_bin[k] > 0) ? m_bin[k] - 1 : 0;
                    m_taken[k]++;
                    if (m_taken[k] == SPT) begin
                        m_taken[k] = 0;
                        m_fin[k]   = 1'b1;
                    end
                end
            end
            if (rst) m_known = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        t_start = 1'b0; t_valid = 1'b0; t_state = 1'b0; t_dec = 1'b0;
    endtask

    task automatic do_start(input int addr);
        t_start = 1'b1; t_addr = AW'(addr);
        tick();
        t_start = 1'b0;
    endtask

    task automatic samples(input int n, input bit st);
        for (int i = 0; i < n; i++) begin
            t_valid = 1'b1; t_state = st;
            tick();
        end
        t_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; t_addr = '0;
        idle_inputs();
        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset_bin", int'(if_a.bin_count_out), 32768);
        check("reset_busy", int'(if_a.busy_out), 0);
        check("reset_trial", int'(if_a.trial_idx_out), 0);

        // 1: four |1> samples, decision stage closes the measurement.
        do_start(5);
        samples(4, 1'b1);
        check("t1_bin", int'(if_a.bin_count_out), 32772);
        check("t1_finish", int'(if_a.finish_trial_out), 1);
        check("t1_last", int'(if_a.last_trial_out), 0);
        check("t1_addr", int'(if_a.threshold_addr_out), 5);
        t_dec = 1'b1;
        tick();
        t_dec = 1'b0;
        check("t1_busy_after", int'(if_a.busy_out), 0);
        check("t1_ready_after", int'(if_a.sample_ready_out), 0);

        // 2: balanced samples, three trials, last trial ends without decision.
        do_start(3);
        for (int t = 0; t < MAXT; t++) begin
            for (int s = 0; s < SPT; s++) begin
                t_valid = 1'b1; t_state = (s % 2 == 0);
                tick();
            end
            t_valid = 1'b0;
            check("t2_finish", int'(if_a.finish_trial_out), 1);
            check("t2_bin", int'(if_a.bin_count_out), 32768);
            check("t2_last", int'(if_a.last_trial_out), (t == MAXT - 1) ? 1 : 0);
            if (t == MAXT - 1) t_start = 1'b1;   // ignored: FINISH is not IDLE
            tick();
            t_start = 1'b0;
        end
        check("t2_idle", int'(if_a.busy_out), 0);

        // 3: valid held through FINISH is not taken; gaps leave the count alone.
        do_start(5);
        t_valid = 1'b1; t_state = 1'b1;
        tick(); tick(); tick(); tick();
        check("t3_ready_in_finish", int'(if_a.sample_ready_out), 0);
        tick();
        t_valid = 1'b0;
        tick(); tick();
        check("t3_bin_gap", int'(if_a.bin_count_out), 32772);
        samples(4, 1'b1);
        check("t3_bin_trial1", int'(if_a.bin_count_out), 32776);
        t_dec = 1'b1;
        tick();
        t_dec = 1'b0;

        // 5: start ignored mid-ACCUM, then reset mid-ACCUM, then a fresh run.
        do_start(5);
        samples(2, 1'b1);
        t_start = 1'b1; t_addr = AW'(9);
        tick();
        t_start = 1'b0;
        check("t5_addr_kept", int'(if_a.threshold_addr_out), 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_bin", int'(if_a.bin_count_out), 32768);
        check("t5_rst_busy", int'(if_a.busy_out), 0);
        check("t5_rst_finish", int'(if_a.finish_trial_out), 0);
        do_start(7);
        samples(3, 1'b0);
        check("t5_new_bin", int'(if_a.bin_count_out), 32765);
        check("t5_new_addr", int'(if_a.threshold_addr_out), 7);
        samples(1, 1'b0);
        t_dec = 1'b1;
        tick();
        t_dec = 1'b0;

        // 4: saturation on the W=4 instance.
        do_start(2);
        for (int t = 0; t < MAXT; t++) begin
            samples(SPT, 1'b0);
            if (t == 1) check("t4_bin_zero_8", int'(if_b.bin_count_out), 0);
            tick();
        end
        check("t4_bin_zero_12", int'(if_b.bin_count_out), 0);
        do_start(2);
        for (int t = 0; t < MAXT; t++) begin
            samples(SPT, 1'b1);
            tick();
        end
        check("t4_bin_sat", int'(if_b.bin_count_out), 15);

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            t_start = ($urandom_range(7) == 0);
            t_addr  = AW'($urandom_range(15));
            t_valid = ($urandom_range(9) < 7);
            t_state = ($urandom_range(9) < ((c / 400) * 2 + 1));
            t_dec   = ($urandom_range(3) == 0);
            rst     = ($urandom_range(149) == 0);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
